cv32e_data_mem_responder: RTL and testbench

// - Responder (slave) end of the CV32E data-side request/grant/rvalid protocol (CORE_DATA_INF_M2S/S2M).
// - Terminates a core data port, or the data-form instruction port, onto a single-port synchronous SRAM macro.
// - Adds wait-state injection, an outstanding-transaction limit and in-order rvalid return after a fixed SRAM latency.
// - Used as the boot/instruction RAM and scratchpad slave in the SoC.

---
 rtl/soc_mem_resp_pkg.sv | 38 +++
 rtl/cv32e_resp_delay_line.sv | 28 ++
 rtl/cv32e_data_mem_responder.sv | 149 ++++++++++++++
 tb/tb_cv32e_data_mem_responder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_mem_resp_pkg.sv
// Shared types for the data-side SRAM responder: the core data bus
// request/response structs, the response tag carried down the latency
// pipe, the grant FSM states and parameter ceilings.
package soc_mem_resp_pkg;

  localparam int MAX_MEM_LATENCY = 4;
  localparam int MAX_GNT_WAIT    = 15;

  // Core data port, master to slave (same layout as the SoC interface list)
  typedef struct packed {
    logic        data_req;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
  } CORE_DATA_INF_M2S;

  // Core data port, slave to master
  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
  } CORE_DATA_INF_S2M;

  // One granted transaction travelling towards its rvalid slot
  typedef struct packed {
    logic valid;
    logic we;
    logic in_win;
  } resp_tag_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GRANT
  } gnt_state_e;

endpackage

// File: rtl/cv32e_resp_delay_line.sv
// Fixed-depth shift register of response tags. A tag entering on cycle N
// appears on tag_o on cycle N+DEPTH, which lines it up with SRAM read data.
module cv32e_resp_delay_line
  import soc_mem_resp_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  resp_tag_t tag_i,
  output resp_tag_t tag_o
);

  resp_tag_t [DEPTH-1:0] tag_pipe;

  // Shift every cycle; reset flushes all in-flight tags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tag_o = tag_pipe[DEPTH-1];

endmodule

// File: rtl/cv32e_data_mem_responder.sv
// Slave end of the core data req/gnt/rvalid protocol onto a single-port
// synchronous SRAM. Adds programmable grant wait states, a cap on
// outstanding transactions and in-order responses after MEM_LATENCY.
module cv32e_data_mem_responder
  import soc_mem_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          MEM_WORDS       = 4096,
  parameter int          MEM_LATENCY     = 1,
  parameter int          GNT_WAIT        = 0,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] ERR_RDATA       = 32'hDEAD_BEEF,
  localparam int         AW              = $clog2(MEM_WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  CORE_DATA_INF_M2S data_slave_inf_m2s,
  output CORE_DATA_INF_S2M data_slave_inf_s2m,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [3:0]       mem_be_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i
);

  localparam int          OW        = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] WIN_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [3:0]  WAIT_LOAD = 4'(GNT_WAIT - 1);

  // ---------------- address decode ----------------
  logic [31:0] offs;
  logic        in_win;
  logic        unused_addr_bits;

  assign offs   = data_slave_inf_m2s.data_addr - BASE_ADDR;
  assign in_win = offs < WIN_BYTES;
  // Byte lane bits and bits above the window are not part of the word address.
  assign unused_addr_bits = ^{offs[31:AW+2], offs[1:0]};

  // ---------------- grant FSM ----------------
  gnt_state_e    state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic [OW-1:0] ost_q;
  logic          can_issue;
  logic          gnt_raw, gnt, xfer;
  logic          req;
  resp_tag_t     tag_in, tag_out;

  assign req       = data_slave_inf_m2s.data_req;
  assign can_issue = ost_q < OW'(MAX_OUTSTANDING);

  // State and wait counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next state and grant. The counter is loaded with GNT_WAIT-1 and GRANT is
  // entered when it would reach zero, so gnt lands exactly GNT_WAIT cycles
  // after the request is first seen with room to issue.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    gnt_raw = 1'b0;
    if (GNT_WAIT == 0) begin
      state_d = IDLE;
      gnt_raw = req & can_issue;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && can_issue) begin
            wcnt_d  = WAIT_LOAD;
            state_d = (GNT_WAIT == 1) ? GRANT : WAIT;
          end
        end
        WAIT: begin
          if (!req) begin
            state_d = IDLE;
          end else begin
            wcnt_d = wcnt_q - 4'd1;
            if (wcnt_q == 4'd1) state_d = GRANT;
          end
        end
        GRANT: begin
          if (!req) begin
            state_d = IDLE;
          end else if (can_issue) begin
            gnt_raw = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Combinational grant must also read 0 while reset is held.
  assign gnt  = gnt_raw & ~rst_i;
  assign xfer = req & gnt;

  // ---------------- SRAM side ----------------
  assign mem_req_o   = xfer & in_win;
  assign mem_we_o    = mem_req_o & data_slave_inf_m2s.data_we;
  assign mem_addr_o  = mem_req_o ? offs[AW+1:2] : '0;
  assign mem_be_o    = mem_req_o ? data_slave_inf_m2s.data_be : 4'h0;
  assign mem_wdata_o = mem_req_o ? data_slave_inf_m2s.data_wdata : 32'h0;

  // ---------------- response path ----------------
  assign tag_in.valid  = xfer;
  assign tag_in.we     = xfer & data_slave_inf_m2s.data_we;
  assign tag_in.in_win = xfer & in_win;

  cv32e_resp_delay_line #(
    .DEPTH (MEM_LATENCY)
  ) u_delay (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // Outstanding count: a grant and a response in the same cycle cancel out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ost_q <= '0;
    end else if (xfer && !tag_out.valid) begin
      ost_q <= ost_q + OW'(1);
    end else if (!xfer && tag_out.valid) begin
      ost_q <= ost_q - OW'(1);
    end
  end

  // Response mux: writes answer 0, out-of-window reads answer ERR_RDATA.
  always_comb begin
    data_slave_inf_s2m             = '0;
    data_slave_inf_s2m.data_gnt    = gnt;
    data_slave_inf_s2m.data_rvalid = tag_out.valid;
    if (tag_out.valid && !tag_out.we) begin
      data_slave_inf_s2m.data_rdata = tag_out.in_win ? mem_rdata_i : ERR_RDATA;
    end
  end

endmodule

// File: tb/tb_cv32e_data_mem_responder.sv
module tb_cv32e_data_mem_responder;
  import soc_mem_resp_pkg::*;

  localparam int NI = 3;
  localparam int MW = 64;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  CORE_DATA_INF_M2S m2s [NI];
  CORE_DATA_INF_S2M s2m [NI];
  logic             mem_req [NI];
  logic             mem_we [NI];
  logic [AW-1:0]    mem_addr [NI];
  logic [3:0]       mem_be [NI];
  logic [31:0]      mem_wdata [NI];

  typedef struct {
    int          due;
    logic [31:0] d;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Power-up / reset contents of each instance's SRAM
  function automatic logic [31:0] init_word(input int inst, input int idx);
    if (inst == 0 && idx == 4) return 32'h1234_5678;
    if (inst == 0 && idx == 8) return 32'h1122_3344;
    return 32'h5A00_0000 + 32'(inst << 16) + 32'(idx);
  endfunction

  // Instance 0: defaults. Instance 1: GNT_WAIT=3, base 0x1000. Instance 2: MEM_LATENCY=3.
  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int          L    = (g == 2) ? 3 : 1;
    localparam int          W    = (g == 1) ? 3 : 0;
    localparam int          MO   = 2;
    localparam logic [31:0] BASE = (g == 1) ? 32'h0000_1000 : 32'h0;

    logic [31:0] mem_rdata;
    logic [31:0] ram [MW];
    logic [31:0] rd_pipe [L];

    cv32e_data_mem_responder #(
      .BASE_ADDR(BASE), .MEM_WORDS(MW), .MEM_LATENCY(L), .GNT_WAIT(W),
      .MAX_OUTSTANDING(MO), .ERR_RDATA(32'hDEAD_BEEF)
    ) dut (
      .clk_i(clk), .rst_i(rst),
      .data_slave_inf_m2s(m2s[g]), .data_slave_inf_s2m(s2m[g]),
      .mem_req_o(mem_req[g]), .mem_we_o(mem_we[g]), .mem_addr_o(mem_addr[g]),
      .mem_be_o(mem_be[g]), .mem_wdata_o(mem_wdata[g]), .mem_rdata_i(mem_rdata)
    );

    // SRAM macro: byte-enabled write, read data L cycles after the strobe
    always @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < MW; k++) ram[k] <= init_word(g, k);
      end else if (mem_req[g] && mem_we[g]) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[g][b]) ram[mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
      end
      rd_pipe[0] <= ram[mem_addr[g]];
      for (int k = 1; k < L; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[L-1];

    // Reference model: expected responses queued at grant time with their due cycle
    exp_t        q[$];
    logic [31:0] ref_mem [MW];
    int          seen;
    int          occ;
    logic        eg, xfer, inw;
    logic [31:0] off, er;

    always @(negedge clk) begin
      if (rst) begin
        chk($sformatf("i%0d_rst_gnt", g), 32'(s2m[g].data_gnt), 0);
        chk($sformatf("i%0d_rst_rvalid", g), 32'(s2m[g].data_rvalid), 0);
        chk($sformatf("i%0d_rst_rdata", g), s2m[g].data_rdata, 0);
        chk($sformatf("i%0d_rst_mem_req", g), 32'(mem_req[g]), 0);
        q.delete();
        seen = 0;
        for (int k = 0; k < MW; k++) ref_mem[k] = init_word(g, k);
      end else begin
        occ = q.size();
        if (occ > 0 && q[0].due == cyc) begin
          chk($sformatf("i%0d_rvalid", g), 32'(s2m[g].data_rvalid), 1);
          chk($sformatf("i%0d_rdata", g), s2m[g].data_rdata, q[0].d);
          void'(q.pop_front());
        end else begin
          chk($sformatf("i%0d_rvalid_idle", g), 32'(s2m[g].data_rvalid), 0);
          chk($sformatf("i%0d_rdata_idle", g), s2m[g].data_rdata, 0);
        end
        // gnt comes W cycles after a request is first seen with room to issue
        eg = m2s[g].data_req && (occ < MO) && (W == 0 || seen == W);
        chk($sformatf("i%0d_gnt", g), 32'(s2m[g].data_gnt), 32'(eg));
        if (!m2s[g].data_req || eg) seen = 0;
        else if (seen > 0 || occ < MO) seen++;
        xfer = m2s[g].data_req && s2m[g].data_gnt;
        if (xfer) begin
          off = m2s[g].data_addr - BASE;
          inw = off < 32'(MW * 4);
          chk($sformatf("i%0d_mem_req", g), 32'(mem_req[g]), 32'(inw));
          if (inw) begin
            chk($sformatf("i%0d_mem_addr", g), 32'(mem_addr[g]), 32'(off[7:2]));
            chk($sformatf("i%0d_mem_we", g), 32'(mem_we[g]), 32'(m2s[g].data_we));
            chk($sformatf("i%0d_mem_be", g), 32'(mem_be[g]), 32'(m2s[g].data_be));
            if (m2s[g].data_we) chk($sformatf("i%0d_mem_wdata", g), mem_wdata[g], m2s[g].data_wdata);
          end
          er = m2s[g].data_we ? 32'h0 : (inw ? ref_mem[off[7:2]] : 32'hDEAD_BEEF);
          if (inw && m2s[g].data_we)
            for (int b = 0; b < 4; b++)
              if (m2s[g].data_be[b]) ref_mem[off[7:2]][8*b +: 8] = m2s[g].data_wdata[8*b +: 8];
          q.push_back('{due: cyc + L, d: er});
        end else begin
          chk($sformatf("i%0d_mem_req_nogrant", g), 32'(mem_req[g]), 0);
        end
      end
    end
  end

  // Drive one request from posedge+1; hold until gnt; report wait cycles and SRAM strobe seen at gnt
  task automatic issue(input int i, input logic [31:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, output int waited, output logic mr,
                       output logic [AW-1:0] ma, output logic [3:0] mb);
    bit got;
    got = 0; waited = 0; mr = 0; ma = '0; mb = '0;
    m2s[i].data_req = 1'b1; m2s[i].data_addr = a; m2s[i].data_we = we;
    m2s[i].data_be = be; m2s[i].data_wdata = wd;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      got = s2m[i].data_gnt;
      if (got) begin mr = mem_req[i]; ma = mem_addr[i]; mb = mem_be[i]; end
      else waited++;
      @(posedge clk); #1;
    end
    m2s[i].data_req = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL issue_timeout inst=%0d addr=%h actual=no_gnt required=gnt", i, a);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  int               w, nrv;
  int               ws [4];
  logic             mr;
  logic [AW-1:0]    ma;
  logic [3:0]       mb;
  logic [31:0]      col[$];

  initial begin
    for (int i = 0; i < NI; i++) m2s[i] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    next_cycle();

    // Single read at 0x10, word 4
    issue(0, 32'h10, 1'b0, 4'hF, 32'h0, w, mr, ma, mb);
    chk("t1_gnt_wait", 32'(w), 0);
    chk("t1_mem_addr", 32'(ma), 4);
    @(negedge clk);
    chk("t1_rvalid", 32'(s2m[0].data_rvalid), 1);
    chk("t1_rdata", s2m[0].data_rdata, 32'h1234_5678);
    next_cycle();

    // Partial write then read back the merged word
    issue(0, 32'h20, 1'b1, 4'b0011, 32'hA5A5_A5A5, w, mr, ma, mb);
    chk("t2_mem_req", 32'(mr), 1);
    chk("t2_mem_be", 32'(mb), 32'h3);
    chk("t2_mem_addr", 32'(ma), 8);
    @(negedge clk);
    chk("t2_wr_rvalid", 32'(s2m[0].data_rvalid), 1);
    chk("t2_wr_rdata", s2m[0].data_rdata, 32'h0);
    next_cycle();
    issue(0, 32'h20, 1'b0, 4'hF, 32'h0, w, mr, ma, mb);
    @(negedge clk);
    chk("t2_rd_rdata", s2m[0].data_rdata, 32'h1122_A5A5);
    next_cycle();

    // be=0 write: SRAM strobed, nothing changes
    issue(0, 32'h22, 1'b1, 4'b0000, 32'hFFFF_FFFF, w, mr, ma, mb);
    chk("be0_mem_req", 32'(mr), 1);
    chk("be0_mem_be", 32'(mb), 0);
    next_cycle();
    issue(0, 32'h20, 1'b0, 4'hF, 32'h0, w, mr, ma, mb);
    @(negedge clk);
    chk("be0_rd_rdata", s2m[0].data_rdata, 32'h1122_A5A5);
    next_cycle();

    // Out-of-window read just past the window, and out-of-window write
    issue(0, 32'h100, 1'b0, 4'hF, 32'h0, w, mr, ma, mb);
    chk("oob_rd_mem_req", 32'(mr), 0);
    @(negedge clk);
    chk("oob_rd_rvalid", 32'(s2m[0].data_rvalid), 1);
    chk("oob_rd_rdata", s2m[0].data_rdata, 32'hDEAD_BEEF);
    next_cycle();
    issue(0, 32'h200, 1'b1, 4'hF, 32'h1357_9BDF, w, mr, ma, mb);
    chk("oob_wr_mem_req", 32'(mr), 0);
    @(negedge clk);
    chk("oob_wr_rvalid", 32'(s2m[0].data_rvalid), 1);
    chk("oob_wr_rdata", s2m[0].data_rdata, 32'h0);
    next_cycle();

    // GNT_WAIT=3: gnt three cycles after req
    issue(1, 32'h1014, 1'b0, 4'hF, 32'h0, w, mr, ma, mb);
    chk("t3_gnt_wait", 32'(w), 3);
    chk("t3_mem_req", 32'(mr), 1);
    chk("t3_mem_addr", 32'(ma), 5);
    @(negedge clk);
    chk("t3_rdata", s2m[1].data_rdata, 32'h5A01_0005);
    next_cycle();

    // Request abandoned during wait states: no gnt, then a clean request
    m2s[1].data_req = 1'b1; m2s[1].data_addr = 32'h1008; m2s[1].data_we = 1'b0;
    m2s[1].data_be = 4'hF; m2s[1].data_wdata = 32'h0;
    next_cycle();
    next_cycle();
    m2s[1].data_req = 1'b0;
    next_cycle();
    issue(1, 32'h1008, 1'b0, 4'hF, 32'h0, w, mr, ma, mb);
    chk("drop_regnt_wait", 32'(w), 3);
    @(negedge clk);
    chk("drop_rdata", s2m[1].data_rdata, 32'h5A01_0002);
    next_cycle();

    // MEM_LATENCY=3, MAX_OUTSTANDING=2: four back-to-back reads
    col.delete();
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          issue(2, 32'(k * 4), 1'b0, 4'hF, 32'h0, w, mr, ma, mb);
          ws[k] = w;
        end
      end
      begin
        for (int n = 0; n < 20; n++) begin
          @(negedge clk);
          if (s2m[2].data_rvalid) col.push_back(s2m[2].data_rdata);
        end
      end
    join
    chk("t4_wait0", 32'(ws[0]), 0);
    chk("t4_wait1", 32'(ws[1]), 0);
    chk("t4_wait2", 32'(ws[2]), 2);
    chk("t4_wait3", 32'(ws[3]), 0);
    chk("t4_rvalid_count", 32'(col.size()), 4);
    for (int k = 0; k < 4 && k < col.size(); k++)
      chk($sformatf("t4_rdata%0d", k), col[k], 32'h5A02_0000 + 32'(k));
    next_cycle();

    // Reset pulse with two reads in flight
    issue(2, 32'h8, 1'b0, 4'hF, 32'h0, w, mr, ma, mb);
    issue(2, 32'hC, 1'b0, 4'hF, 32'h0, w, mr, ma, mb);
    next_cycle();
    #1 chk("t6_pre_rvalid", 32'(s2m[2].data_rvalid), 1);
    #1 rst = 1'b1;
    #1 chk("t6_async_rvalid", 32'(s2m[2].data_rvalid), 0);
    chk("t6_async_rdata", s2m[2].data_rdata, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    nrv = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (s2m[2].data_rvalid) nrv++;
    end
    chk("t6_no_stale_rvalid", 32'(nrv), 0);
    next_cycle();
    issue(2, 32'h4, 1'b0, 4'hF, 32'h0, w, mr, ma, mb);
    chk("t6_after_gnt_wait", 32'(w), 0);
    repeat (3) @(negedge clk);
    chk("t6_after_rvalid", 32'(s2m[2].data_rvalid), 1);
    chk("t6_after_rdata", s2m[2].data_rdata, 32'h5A02_0001);
    next_cycle();
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
